// File: rtl/fetch_pkg.sv
// fetch_pkg: redirect-kind codes and default vectors shared by the IF-stage PC logic.
package fetch_pkg;
    localparam logic [2:0] RK_SEQ = 3'd0;
    localparam logic [2:0] RK_BR  = 3'd1;
    localparam logic [2:0] RK_J   = 3'd2;
    localparam logic [2:0] RK_JR  = 3'd3;
    localparam logic [2:0] RK_EXC = 3'd4;
    localparam logic [2:0] RK_ILL = 3'd5;
    localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEF_ILL_VEC   = 32'h8000_0008;
endpackage

// File: rtl/fetch_ras.sv
// fetch_ras: circular return-address stack; a push at full overwrites the oldest entry.
module fetch_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW:0] count;
    assign empty = count == '0;
    assign top = empty ? '0 : mem[ptr];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            count <= '0;
        end else if (push && (!pop || empty)) begin
            ptr <= ptr + PW'(1);
            count <= count == FULL ? count : count + (PW+1)'(1);
        end else if (pop && !push && !empty) begin
            ptr <= ptr - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end
    // push+pop on a non-empty stack replaces the top entry in place
    always_ff @(posedge clk)
        if (push) mem[(pop && !empty) ? ptr : ptr + PW'(1)] <= push_data;
endmodule

// File: rtl/pipeline_fetch_pc.sv
// pipeline_fetch_pc: IF-stage next-PC select with stall-safe pending redirect.
// Optional return-address stack enabled by defining FETCH_RAS_EN.
module pipeline_fetch_pc import fetch_pkg::*; #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC),
    parameter logic [XLEN-1:0] ILL_VEC   = XLEN'(DEF_ILL_VEC),
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [2:0]      redir_kind,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic [25:0]     jt,
    input  logic [XLEN-1:0] jr_target,
    input  logic            fwd_valid,
    input  logic [XLEN-2:0] fwd_pc,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            redir_pending,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty
);
    logic is_br, is_j, is_jr, is_ill, is_exc, req_valid;
    logic [XLEN-1:0] req_target, pend_target;
    assign pc_plus4 = pc + XLEN'(4);
    assign is_br  = redir_kind == RK_BR && br_taken;
    assign is_j   = redir_kind == RK_J;
    assign is_jr  = redir_kind == RK_JR;
    assign is_ill = redir_kind == RK_ILL;
    assign is_exc = redir_kind == RK_EXC;
    assign req_valid = is_br || is_j || fwd_valid || is_jr || is_ill;
    assign req_target = is_br     ? br_target :
                        is_j      ? {pc[XLEN-1:28], jt, 2'b00} :
                        fwd_valid ? {1'b0, fwd_pc} :
                        is_jr     ? jr_target :
                        is_ill    ? ILL_VEC : pc_plus4;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VEC;
            redir_pending <= 1'b0;
            pend_target <= '0;
        end else if (is_exc) begin
            pc <= EXC_VEC;
            redir_pending <= 1'b0;
        end else if (stall) begin
            if (!redir_pending && req_valid) begin
                redir_pending <= 1'b1;
                pend_target <= req_target;
            end
        end else if (redir_pending) begin
            pc <= pend_target;
            redir_pending <= 1'b0;
        end else begin
            pc <= req_target;
        end
    end
`ifdef FETCH_RAS_EN
    fetch_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk),
        .reset(reset),
        .push(ras_push && !stall),
        .pop(ras_pop && !stall),
        .push_data(pc_plus4),
        .top(ras_top),
        .empty(ras_empty)
    );
`else
    logic unused_ras;
    assign unused_ras = ras_push ^ ras_pop;
    assign ras_top = '0;
    assign ras_empty = 1'b1;
`endif
endmodule

// File: tb/tb_pipeline_fetch_pc.sv
// tb_pipeline_fetch_pc: scoreboard bench; expectations queued per step, checked by a monitor.
module tb_pipeline_fetch_pc;
    import fetch_pkg::*;
    logic clk = 1'b0, reset = 1'b1;
    logic stall, br_taken, fwd_valid, ras_push, ras_pop;
    logic [2:0] redir_kind;
    logic [31:0] br_target, jr_target;
    logic [25:0] jt;
    logic [30:0] fwd_pc;
    logic [31:0] pc, pc_plus4, ras_top;
    logic redir_pending, ras_empty;

    pipeline_fetch_pc dut (
        .clk(clk), .reset(reset), .stall(stall), .redir_kind(redir_kind),
        .br_taken(br_taken), .br_target(br_target), .jt(jt), .jr_target(jr_target),
        .fwd_valid(fwd_valid), .fwd_pc(fwd_pc), .ras_push(ras_push), .ras_pop(ras_pop),
        .pc(pc), .pc_plus4(pc_plus4), .redir_pending(redir_pending),
        .ras_top(ras_top), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int due;
        logic [31:0] pc;
        logic pend;
        logic [31:0] top;
        logic empty;
    } exp_t;
    exp_t sb[$];
    int cyc = 0, tests = 0, fails = 0;

    initial forever @(posedge clk) cyc++;

    initial forever begin
        @(negedge clk);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (pc !== e.pc || pc_plus4 !== e.pc + 32'd4 || redir_pending !== e.pend ||
                ras_top !== e.top || ras_empty !== e.empty) begin
                fails++;
                $display("FAIL %s: got pc=%h pc4=%h pend=%b top=%h empty=%b, want pc=%h pc4=%h pend=%b top=%h empty=%b",
                         e.nm, pc, pc_plus4, redir_pending, ras_top, ras_empty,
                         e.pc, e.pc + 32'd4, e.pend, e.top, e.empty);
            end
        end
    end

    task automatic idle();
        stall = 0; redir_kind = RK_SEQ; br_taken = 0; br_target = '0; jt = '0;
        jr_target = '0; fwd_valid = 0; fwd_pc = '0; ras_push = 0; ras_pop = 0;
    endtask

    task automatic go(input string nm, input logic [31:0] epc, input logic epend,
                      input logic [31:0] etop, input logic eempty);
        exp_t e;
`ifdef FETCH_RAS_EN
        e = '{nm, cyc + 1, epc, epend, etop, eempty};
`else
        e = '{nm, cyc + 1, epc, epend, 32'h0, 1'b1};
`endif
        sb.push_back(e);
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        @(negedge clk);
        go("reset", 32'h8000_0000, 0, 0, 1);
        reset = 0;
        go("seq0", 32'h8000_0004, 0, 0, 1);
        go("seq1", 32'h8000_0008, 0, 0, 1);
        go("seq2", 32'h8000_000C, 0, 0, 1);
        go("seq3", 32'h8000_0010, 0, 0, 1);
        stall = 1; redir_kind = RK_J; jt = 26'h0000100;
        go("stall_j_a", 32'h8000_0010, 1, 0, 1);
        stall = 1; redir_kind = RK_J; jt = 26'h0000100;
        go("stall_j_b", 32'h8000_0010, 1, 0, 1);
        go("apply_pend", 32'h8000_0400, 0, 0, 1);
        stall = 1; redir_kind = RK_J; jt = 26'h0000100;
        go("latch2", 32'h8000_0400, 1, 0, 1);
        stall = 1; redir_kind = RK_EXC;
        go("exc_over_pend", 32'h8000_0004, 0, 0, 1);
        go("after_exc", 32'h8000_0008, 0, 0, 1);
        redir_kind = RK_BR; br_taken = 1; br_target = 32'h8000_0100; fwd_valid = 1; fwd_pc = 31'h200;
        go("br_over_fwd", 32'h8000_0100, 0, 0, 1);
        redir_kind = RK_BR; br_taken = 0; br_target = 32'h8000_0100; fwd_valid = 1; fwd_pc = 31'h200;
        go("nt_to_fwd", 32'h0000_0200, 0, 0, 1);
        go("seq_after_fwd", 32'h0000_0204, 0, 0, 1);
        redir_kind = RK_JR; jr_target = 32'h1234_5678; fwd_valid = 1; fwd_pc = 31'h7FFF_FFF0;
        go("fwd_over_jr", 32'h7FFF_FFF0, 0, 0, 1);
        redir_kind = RK_JR; jr_target = 32'h1234_5678;
        go("jr", 32'h1234_5678, 0, 0, 1);
        redir_kind = RK_ILL;
        go("ill", 32'h8000_0008, 0, 0, 1);
        redir_kind = 3'd6;
        go("kind6_seq", 32'h8000_000C, 0, 0, 1);
        redir_kind = RK_J; jt = 26'h3FF_FFFF;
        go("j_region", 32'h8FFF_FFFC, 0, 0, 1);
        redir_kind = RK_JR; jr_target = 32'hFFFF_FFFC;
        go("jr_top", 32'hFFFF_FFFC, 0, 0, 1);
        go("wrap", 32'h0000_0000, 0, 0, 1);
        stall = 1; redir_kind = RK_JR; jr_target = 32'h0000_1000;
        go("latch_jr", 32'h0000_0000, 1, 0, 1);
        stall = 1; redir_kind = RK_ILL;
        go("ignore_while_pend", 32'h0000_0000, 1, 0, 1);
        redir_kind = RK_ILL;
        go("pend_beats_req", 32'h0000_1000, 0, 0, 1);
        stall = 1; ras_push = 1;
        go("stall_hold", 32'h0000_1000, 0, 0, 1);
        redir_kind = RK_JR; jr_target = 32'h8000_0000;
        go("to_ras_base", 32'h8000_0000, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            ras_push = 1; redir_kind = RK_JR; jr_target = 32'h8000_0000 + 32'(16 * (i + 1));
            go("push", 32'h8000_0000 + 32'(16 * (i + 1)), 0, 32'h8000_0004 + 32'(16 * i), 0);
        end
        ras_pop = 1; go("pop1", 32'h8000_0054, 0, 32'h8000_0034, 0);
        ras_pop = 1; go("pop2", 32'h8000_0058, 0, 32'h8000_0024, 0);
        ras_pop = 1; go("pop3", 32'h8000_005C, 0, 32'h8000_0014, 0);
        ras_pop = 1; go("pop4_empty", 32'h8000_0060, 0, 0, 1);
        ras_pop = 1; go("pop5_noop", 32'h8000_0064, 0, 0, 1);
        stall = 1; ras_push = 1;
        go("stall_push_ignored", 32'h8000_0064, 0, 0, 1);
        redir_kind = RK_JR; jr_target = 32'h8000_0010;
        go("to_10", 32'h8000_0010, 0, 0, 1);
        ras_push = 1; redir_kind = RK_JR; jr_target = 32'h8000_0020;
        go("push_one", 32'h8000_0020, 0, 32'h8000_0014, 0);
        ras_push = 1; ras_pop = 1;
        go("push_pop_replace", 32'h8000_0024, 0, 32'h8000_0024, 0);
        redir_kind = RK_EXC;
        go("exc_keeps_ras", 32'h8000_0004, 0, 32'h8000_0024, 0);
        ras_pop = 1;
        go("pop_to_empty", 32'h8000_0008, 0, 0, 1);
        ras_push = 1; ras_pop = 1;
        go("push_pop_empty", 32'h8000_000C, 0, 32'h8000_000C, 0);
        ras_pop = 1;
        go("pop_final", 32'h8000_0010, 0, 0, 1);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
